uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit period; legal values are 2 and above.
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port tx_data  input  8  byte to transmit; sampled only at acceptance.
REQ-005 SHALL provide port tx_valid  input  1  upstream byte-available qualifier.
REQ-006 SHALL provide port tx_ready  output  1  high when the block can accept a byte.
REQ-007 SHALL provide port tx  output  1  serial line; idle high.
REQ-008 SHALL provide port busy  output  1  high while a frame is on the line.
REQ-009 SHALL provide port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL use FSM states IDLE, START, DATA, PARITY (macro-dependent), STOP.
REQ-011 SHALL accept a byte on a rising edge where tx_valid and tx_ready are both high, latch tx_data, and enter START.
REQ-012 SHALL drive tx_ready high only in IDLE; tx_valid SHALL be ignored in all other states.
REQ-013 SHALL drive tx low starting the cycle after acceptance, for exactly CLKS_PER_BIT cycles (START).
REQ-014 SHALL then shift out latched bits 0..7, LSB first, each held for exactly CLKS_PER_BIT cycles (DATA), with a 3-bit index that increments per bit and leaves DATA after index 7.
REQ-015 SHALL drive tx high for exactly CLKS_PER_BIT cycles (STOP), then return to IDLE.
REQ-016 SHALL use a baud counter of width $clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1, clears on every state or bit change, and never wraps mid-bit.
REQ-017 SHALL assert tx_done for exactly one cycle: the first IDLE cycle after STOP.
REQ-018 SHALL assert busy in every non-IDLE state; busy equals ~tx_ready.
REQ-019 SHALL ignore changes on tx_data after acceptance; the transmitted byte is the latched value.
REQ-020 SHALL allow back-to-back frames: a byte offered during the tx_done cycle is accepted, and START begins on the next cycle with no extra idle bit.
REQ-021 SHALL drive tx high in IDLE at all times.

Reset
REQ-022 SHALL on reset force state IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, baud counter=0, bit index=0, latched data=0.
REQ-023 SHALL, on reset asserted mid-frame, abandon the frame, drive tx=1 from the following cycle, and suppress tx_done.
REQ-024 SHALL give reset priority over acceptance when both occur in the same cycle; the byte is not accepted.

Configuration
REQ-025 SHALL, when macro UART_TX_PARITY_EN is defined, insert PARITY between DATA and STOP, driving even parity (XOR of the 8 latched bits) for CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT cycles.
REQ-026 SHALL, when UART_TX_PARITY_EN is undefined, omit PARITY entirely (DATA goes directly to STOP); frame = 10*CLKS_PER_BIT cycles.

Verification
REQ-027 SHALL cover: CLKS_PER_BIT=16, accept 0x55 at cycle 0 -> tx low cycles 1-16, then 1,0,1,0,1,0,1,0 per 16 cycles, stop high cycles 145-160, tx_done at cycle 161.
REQ-028 SHALL cover: tx_valid held high with 0xA3 then 0x0F -> second START begins the cycle after the first tx_done; no extra idle bit on tx.
REQ-029 SHALL cover: tx_data changed from 0x3C to 0xFF during DATA -> line carries 0x3C.
REQ-030 SHALL cover: reset pulsed at cycle 70 of a 0x00 frame -> tx=1, tx_ready=1 next cycle; no tx_done; next frame transmits correctly.
REQ-031 SHALL cover: UART_TX_PARITY_EN defined, bytes 0x07 and 0x03 -> parity bit 1 and 0, respectively; tx_done at cycle 177 for CLKS_PER_BIT=16.
REQ-032 SHALL cover: CLKS_PER_BIT=2, byte 0xFF -> every bit lasts exactly 2 cycles; frame length 20 cycles without parity.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    data;
  logic [2:0]    next_idx;
  logic          baud_last;

  assign next_idx  = bit_idx + 3'd1;
  assign baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      data     <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx      <= 1'b1;
          baud    <= '0;
          bit_idx <= '0;
          if (tx_valid && tx_ready) begin
            data     <= tx_data;
            state    <= START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            baud  <= '0;
            state <= DATA;
            tx    <= data[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= ^data;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= next_idx;
              tx      <= data[next_idx];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud  <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud     <= '0;
            state    <= IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer (CLKS_PER_BIT 16 and 2).
// Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int FB  = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int FB  = 10;
`endif
  localparam int CPB = 16;
  localparam int N   = FB * CPB;
  localparam int N2  = FB * 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, tx_done;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx2, busy2, tx_done2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx),
    .busy(busy), .tx_done(tx_done)
  );

  uart_tx_framer #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .reset(reset),
    .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2),
    .busy(busy2), .tx_done(tx_done2)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         chg_cycle;
    logic [7:0] chg_val;
    logic       b2b;
  } vec_t;

  vec_t vec[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b,
                                   input logic p,
                                   input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR && idx == 9) return p;
    return 1'b1;
  endfunction

  // Called right after the accepting edge; samples mid-cycle.
  task automatic check_frame(input logic [7:0] b,
                             input logic p,
                             input int chg_cycle,
                             input logic [7:0] chg_val);
    int mism = 0;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      if (tx !== exp_bit(b, p, (k - 1) / CPB)) mism++;
      if (k == 1)
        chk("busy_in_frame", {30'd0, busy, tx_ready}, 32'd2);
      if (k == N)
        chk("no_early_done", {31'd0, tx_done}, 32'd0);
      if (k == chg_cycle) tx_data = chg_val;
    end
    chk($sformatf("frame_tx_%02h", b), mism, 0);
    @(negedge clk);
    chk("done_cycle", {28'd0, tx_done, tx_ready, busy, tx},
        32'hD);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit pend;
    int dones;
    int mism;

    vec[0] = '{8'h55, 1'b0, 0,  8'h00, 1'b0};
    vec[1] = '{8'hA3, 1'b0, 0,  8'h00, 1'b1};
    vec[2] = '{8'h0F, 1'b0, 0,  8'h00, 1'b0};
    vec[3] = '{8'h3C, 1'b0, 40, 8'hFF, 1'b0};
    vec[4] = '{8'h07, 1'b1, 0,  8'h00, 1'b0};
    vec[5] = '{8'h03, 1'b0, 0,  8'h00, 1'b0};
    vec[6] = '{8'h00, 1'b0, 0,  8'h00, 1'b0};
    vec[7] = '{8'hFF, 1'b0, 0,  8'h00, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {28'd0, tx_done, tx_ready, busy, tx},
        32'h5);
    chk("reset_state2", {28'd0, tx_done2, tx_ready2, busy2, tx2},
        32'h5);

    pend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!pend) begin
        @(negedge clk);
        chk("ready_idle", {31'd0, tx_ready}, 32'd1);
        tx_data  = vec[i].data;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
      end
      if (vec[i].b2b) tx_data = vec[i+1].data;
      else tx_valid = 1'b0;
      check_frame(vec[i].data, vec[i].par,
                  vec[i].chg_cycle, vec[i].chg_val);
      if (vec[i].b2b) begin
        @(posedge clk);
        #1;
        pend = 1'b1;
      end else begin
        pend = 1'b0;
      end
    end

    // Mid-frame reset during a 0x00 frame
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    mism = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (tx !== 1'b0) mism++;
    end
    chk("pre_reset_tx", mism, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("after_reset", {28'd0, tx_done, tx_ready, busy, tx},
        32'h5);
    dones = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_done) dones++;
      if (!tx) dones++;
    end
    chk("no_done_after_reset", dones, 0);

    @(negedge clk);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check_frame(8'h96, 1'b0, 0, 8'h00);

    // Reset wins over a same-cycle acceptance
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    reset    = 1'b0;
    mism = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if ({tx_ready, busy, tx} !== 3'b101) mism++;
    end
    chk("reset_over_accept", mism, 0);

    // CLKS_PER_BIT=2 with 0xFF
    @(negedge clk);
    tx_data2  = 8'hFF;
    tx_valid2 = 1'b1;
    @(posedge clk);
    #1 tx_valid2 = 1'b0;
    mism = 0;
    for (int k = 1; k <= N2; k++) begin
      @(negedge clk);
      if (tx2 !== exp_bit(8'hFF, 1'b0, (k - 1) / 2)) mism++;
      if (busy2 !== 1'b1) mism++;
      if (tx_done2 !== 1'b0) mism++;
    end
    chk("cpb2_frame", mism, 0);
    @(negedge clk);
    chk("cpb2_done", {28'd0, tx_done2, tx_ready2, busy2, tx2},
        32'hD);
    @(negedge clk);
    chk("cpb2_done_pulse", {31'd0, tx_done2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
